// File: rtl/memory_responder_if.sv
// memory_responder_if: request/response bundle between the core's
// control unit (master) and the memory responder (slave).
interface memory_responder_if;
   logic        request_valid;
   logic        request_write;
   logic [31:0] request_address;
   logic [31:0] request_wdata;
   logic [3:0]  request_byte_enable;
   logic        request_ready;
   logic        response_valid;
   logic [31:0] response_rdata;
   logic        response_error;

   modport master (
      output request_valid,
      output request_write,
      output request_address,
      output request_wdata,
      output request_byte_enable,
      input  request_ready,
      input  response_valid,
      input  response_rdata,
      input  response_error
   );

   modport slave (
      input  request_valid,
      input  request_write,
      input  request_address,
      input  request_wdata,
      input  request_byte_enable,
      output request_ready,
      output response_valid,
      output response_rdata,
      output response_error
   );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: word memory answering one request at a time after
// WAIT_CYCLES wait states. MEMORY_RESPONDER_ALIGN_CHECK_EN faults misalignment.
module memory_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input logic               i_clock,
   input logic               i_reset,
   memory_responder_if.slave bus
);
   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT     = 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESPOND
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_count;
   logic        r_write;
   logic [31:0] r_address;
   logic [31:0] r_wdata;
   logic [3:0]  r_byte_enable;
   logic        r_ready;
   logic        r_valid;
   logic        r_error;
   logic [31:0] r_rdata;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_enter;
   logic          w_write;
   logic          w_fault;
   logic          w_commit;
   logic [31:0]   w_address;
   logic [AW-1:0] w_index;
   logic [AW-1:0] w_commit_index;

   function automatic logic f_fault(input logic [31:0] a);
      logic bad;
      bad = ({1'b0, a} >= LIMIT);
`ifdef MEMORY_RESPONDER_ALIGN_CHECK_EN
      bad = bad | (a[1:0] != 2'b00);
`endif
      return bad;
   endfunction

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (bus.request_valid)
               w_next = (WAIT_CYCLES == 0) ? S_RESPOND : S_WAIT;
         S_WAIT:
            if (r_count == 4'd1) w_next = S_RESPOND;
         S_RESPOND: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // With zero wait states the access happens on the accept edge itself,
   // so the live request fields are used instead of the latched copy.
   assign w_accept  = (r_state == S_IDLE) && bus.request_valid;
   assign w_enter   = (w_next == S_RESPOND);
   assign w_address = (r_state == S_IDLE) ? bus.request_address : r_address;
   assign w_write   = (r_state == S_IDLE) ? bus.request_write : r_write;
   assign w_fault   = f_fault(w_address);
   assign w_index   = w_address[AW+1:2];

   assign w_commit_index = r_address[AW+1:2];
   assign w_commit = (r_state == S_RESPOND) && r_write && !i_reset
                     && !f_fault(r_address);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_count       <= 4'd0;
         r_write       <= 1'b0;
         r_address     <= 32'd0;
         r_wdata       <= 32'd0;
         r_byte_enable <= 4'd0;
         r_ready       <= 1'b1;
         r_valid       <= 1'b0;
         r_error       <= 1'b0;
         r_rdata       <= 32'd0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == S_IDLE);
         r_valid <= w_enter;
         r_error <= w_enter && w_fault;
         r_rdata <= 32'd0;
         if (w_enter && !w_fault && !w_write)
            r_rdata <= r_mem[w_index];
         if (w_accept) begin
            r_write       <= bus.request_write;
            r_address     <= bus.request_address;
            r_wdata       <= bus.request_wdata;
            r_byte_enable <= bus.request_byte_enable;
            r_count       <= WAIT_INIT;
         end else if (r_state == S_WAIT) begin
            r_count <= r_count - 4'd1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (r_byte_enable[b])
               r_mem[w_commit_index][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end

   assign bus.request_ready  = r_ready & ~i_reset;
   assign bus.response_valid = r_valid & ~i_reset;
   assign bus.response_rdata = r_rdata;
   assign bus.response_error = r_error;
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench driving one responder with one
// wait state (instance A) and one with none (instance B).
module tb_memory_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef MEMORY_RESPONDER_ALIGN_CHECK_EN
   localparam bit ALN = 1'b1;
`else
   localparam bit ALN = 1'b0;
`endif
   localparam int LAT_A = 2;

   memory_responder_if bus_a ();
   memory_responder_if bus_b ();

   memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus_a.slave)
   );

   memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus_b.slave)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] rd;
      bit          er;
   } op_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic drive(input bit inst, input bit v, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
      if (inst) begin
         bus_b.request_valid       = v;
         bus_b.request_write       = w;
         bus_b.request_address     = a;
         bus_b.request_wdata       = d;
         bus_b.request_byte_enable = be;
      end else begin
         bus_a.request_valid       = v;
         bus_a.request_write       = w;
         bus_a.request_address     = a;
         bus_a.request_wdata       = d;
         bus_a.request_byte_enable = be;
      end
   endtask

   function automatic logic rdy(input bit inst);
      return inst ? bus_b.request_ready : bus_a.request_ready;
   endfunction

   function automatic logic rv(input bit inst);
      return inst ? bus_b.response_valid : bus_a.response_valid;
   endfunction

   function automatic logic [31:0] rdat(input bit inst);
      return inst ? bus_b.response_rdata : bus_a.response_rdata;
   endfunction

   function automatic logic rerr(input bit inst);
      return inst ? bus_b.response_error : bus_a.response_error;
   endfunction

   // One request; returns response fields and cycles from accept to pulse.
   task automatic access(input bit inst, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output logic [31:0] rd, output logic er,
                         output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!rdy(inst) && n < 20) begin
         @(negedge clk);
         n++;
      end
      drive(inst, 1'b1, w, a, d, be);
      @(posedge clk);
      #1;
      drive(inst, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rv(inst) && lat < 20);
      rd = rdat(inst);
      er = rerr(inst);
   endtask

   task automatic checksum(output logic [31:0] cs);
      logic [31:0] rd;
      logic        er;
      int          lat;
      cs = 32'd0;
      for (int i = 0; i < 1024; i++) begin
         access(1'b0, 1'b0, 32'(4 * i), 32'd0, 4'd0, rd, er, lat);
         cs = {cs[30:0], cs[31]} ^ rd ^ 32'(i);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (rdy(0) !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready_a: got %b want 0", rdy(0));
      end
      total++;
      if (rdy(1) !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready_b: got %b want 0", rdy(1));
      end
      total++;
      if ({rv(0), rdat(0), rerr(0)} !== 34'd0) begin
         bad++;
         $display("FAIL reset_resp_a: got v=%b rd=%h e=%b want 0",
                  rv(0), rdat(0), rerr(0));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (rdy(0) !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_ready_a: got %b want 1", rdy(0));
      end
      total++;
      if (rdy(1) !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_ready_b: got %b want 1", rdy(1));
      end
   endtask

   task automatic test_reset_mid_store();
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          pulses;
      exp_t        e;
      op_t         t[2];
      t[0] = '{1'b1, 32'h00C, 32'h11223344, 4'hF, 32'h0, 1'b0};
      t[1] = '{1'b0, 32'h00C, 32'h0, 4'h0, 32'h11223344, 1'b0};
      sb.push_back('{t[0].rd, t[0].er, LAT_A});
      access(1'b0, t[0].w, t[0].a, t[0].d, t[0].be, rd, er, lat);
      e = sb.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
         bad++;
         $display("FAIL rst_preload: got %h/%b/%0d want %h/%b/%0d",
                  rd, er, lat, e.rdata, e.err, e.lat);
      end
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h00C, 32'hCAFEF00D, 4'hF);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      rst = 1'b1;
      pulses = 0;
      @(negedge clk);
      if (rv(0)) pulses++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (rdy(0) !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_ready: got %b want 1", rdy(0));
      end
      for (int i = 0; i < 4; i++) begin
         if (rv(0)) pulses++;
         @(negedge clk);
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL rst_mid_pulse: got %0d pulses want 0", pulses);
      end
      sb.push_back('{t[1].rd, t[1].er, LAT_A});
      access(1'b0, t[1].w, t[1].a, t[1].d, t[1].be, rd, er, lat);
      e = sb.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
         bad++;
         $display("FAIL rst_old_value: got %h/%b/%0d want %h/%b/%0d",
                  rd, er, lat, e.rdata, e.err, e.lat);
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd;
      logic        er;
      int          lat;
      exp_t        e;
      op_t         t[2];
      t[0] = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
      t[1] = '{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
      foreach (t[i]) begin
         sb.push_back('{t[i].rd, t[i].er, LAT_A});
         access(1'b0, t[i].w, t[i].a, t[i].d, t[i].be, rd, er, lat);
         e = sb.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            bad++;
            $display("FAIL store_load[%0d]: got %h/%b/%0d want %h/%b/%0d",
                     i, rd, er, lat, e.rdata, e.err, e.lat);
         end
      end
   endtask

   task automatic test_partial();
      logic [31:0] rd;
      logic        er;
      int          lat;
      exp_t        e;
      op_t         t[6];
      t[0] = '{1'b1, 32'h010, 32'h000000AA, 4'b0001, 32'h0, 1'b0};
      t[1] = '{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0};
      t[2] = '{1'b1, 32'h010, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0};
      t[3] = '{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0};
      t[4] = '{1'b1, 32'h010, 32'h55660000, 4'b1100, 32'h0, 1'b0};
      t[5] = '{1'b0, 32'h010, 32'h0, 4'h0, 32'h5566BEAA, 1'b0};
      foreach (t[i]) begin
         sb.push_back('{t[i].rd, t[i].er, LAT_A});
         access(1'b0, t[i].w, t[i].a, t[i].d, t[i].be, rd, er, lat);
         e = sb.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            bad++;
            $display("FAIL partial[%0d]: got %h/%b/%0d want %h/%b/%0d",
                     i, rd, er, lat, e.rdata, e.err, e.lat);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          idx;
      int          k;
      logic        seen;
      exp_t        e;
      logic [31:0] val[5];
      for (int i = 0; i < 5; i++) begin
         val[i] = 32'hA5000000 ^ (32'h01010101 * 32'(i + 1));
         access(1'b1, 1'b1, 32'(32'h40 + 4 * i), val[i], 4'hF, rd, er, lat);
         total++;
         if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin
            bad++;
            $display("FAIL b2b_preload[%0d]: got %h/%b/%0d want 0/0/1",
                     i, rd, er, lat);
         end
      end
      for (int i = 0; i < 5; i++) sb.push_back('{val[i], 1'b0, 2 * i + 1});
      idx = 0;
      k   = 0;
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 4'd0);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         seen = rdy(1);
         total++;
         if (seen !== ((c % 2) == 0)) begin
            bad++;
            $display("FAIL b2b_ready[%0d]: got %b want %b",
                     c, seen, (c % 2) == 0);
         end
         if (rv(1) && sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (rdat(1) !== e.rdata || rerr(1) !== e.err || c != e.lat) begin
               bad++;
               $display("FAIL b2b_resp[%0d]: got %h/%b@%0d want %h/%b@%0d",
                        k, rdat(1), rerr(1), c, e.rdata, e.err, e.lat);
            end
            k++;
         end
         @(posedge clk);
         #1;
         if (seen) begin
            idx++;
            if (idx < 5)
               drive(1'b1, 1'b1, 1'b0, 32'(32'h40 + 4 * idx), 32'd0, 4'd0);
            else
               drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
         end
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL b2b_count: got %0d responses want 5", k);
         sb.delete();
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [31:0] cs0;
      logic [31:0] cs1;
      exp_t        e;
      op_t         t[5];
      t[0] = '{1'b1, 32'h00000FFC, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0};
      t[1] = '{1'b0, 32'h00000FFC, 32'h0, 4'h0, 32'h0BADC0DE, 1'b0};
      t[2] = '{1'b0, 32'h00001000, 32'h0, 4'h0, 32'h0, 1'b1};
      t[3] = '{1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1};
      t[4] = '{1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
      checksum(cs0);
      foreach (t[i]) begin
         sb.push_back('{t[i].rd, t[i].er, LAT_A});
         access(1'b0, t[i].w, t[i].a, t[i].d, t[i].be, rd, er, lat);
         e = sb.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            bad++;
            $display("FAIL range[%0d]: got %h/%b/%0d want %h/%b/%0d",
                     i, rd, er, lat, e.rdata, e.err, e.lat);
         end
         if (i == 3) checksum(cs0);
      end
      checksum(cs1);
      total++;
      if (cs1 !== cs0) begin
         bad++;
         $display("FAIL range_checksum: got %h want %h", cs1, cs0);
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd;
      logic        er;
      int          lat;
      exp_t        e;
      op_t         t[4];
      t[0] = '{1'b1, 32'h010, 32'h12345678, 4'hF, 32'h0, 1'b0};
      t[1] = '{1'b0, 32'h012, 32'h0, 4'h0,
               ALN ? 32'h0 : 32'h12345678, ALN};
      t[2] = '{1'b1, 32'h013, 32'h0, 4'hF, 32'h0, ALN};
      t[3] = '{1'b0, 32'h010, 32'h0, 4'h0,
               ALN ? 32'h12345678 : 32'h0, 1'b0};
      foreach (t[i]) begin
         sb.push_back('{t[i].rd, t[i].er, LAT_A});
         access(1'b0, t[i].w, t[i].a, t[i].d, t[i].be, rd, er, lat);
         e = sb.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
            bad++;
            $display("FAIL misalign[%0d]: got %h/%b/%0d want %h/%b/%0d",
                     i, rd, er, lat, e.rdata, e.err, e.lat);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_reset_mid_store();
      test_store_load();
      test_partial();
      test_back_to_back();
      test_out_of_range();
      test_misaligned();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
